// File: rtl/hub75_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hub75_pkg
//  Description : Shared types and constants for the HUB75 stream loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package hub75_pkg;

    localparam int ERR_CNT_W = 8;
    localparam int PIXEL_BPP = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } loader_state_t;

    typedef logic [2:0][PIXEL_BPP-1:0] pixel_t;

    // Counter/address widths never collapse to zero bits for 1-wide dimensions
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hub75_stream_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : hub75_stream_loader_if
//  Description : Pixel stream input and framebuffer write port of the loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hub75_stream_loader_if
    import hub75_pkg::*;
#(
    parameter int hpixel_p = 64,
    parameter int vpixel_p = 64,
    parameter int bpp_p    = 8
);
    localparam int addr_width_p = clog2_min1(hpixel_p * vpixel_p);

    logic                    i_s_valid;
    logic                    o_s_ready;
    logic [3*bpp_p-1:0]      i_s_data;
    logic                    i_s_sof;
    logic                    i_s_eol;
    logic [addr_width_p-1:0] o_framebuf_wr_addr;
    logic [3*bpp_p-1:0]      o_framebuf_wr_data;
    logic                    o_framebuf_wr_en;
    logic                    i_framebuf_wr_ready;

    // master: the loader; slave: stream source plus framebuffer
    modport master (
        input  i_s_valid, i_s_data, i_s_sof, i_s_eol, i_framebuf_wr_ready,
        output o_s_ready, o_framebuf_wr_addr, o_framebuf_wr_data, o_framebuf_wr_en
    );

    modport slave (
        output i_s_valid, i_s_data, i_s_sof, i_s_eol, i_framebuf_wr_ready,
        input  o_s_ready, o_framebuf_wr_addr, o_framebuf_wr_data, o_framebuf_wr_en
    );

endinterface
`default_nettype wire

// File: rtl/hub75_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : hub75_skid_buf
//  Description : 2-entry write buffer with a registered upstream ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module hub75_skid_buf #(
    parameter int width_p = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_enable,
    input  logic               i_valid,
    input  logic [width_p-1:0] i_data,
    output logic               o_ready,
    output logic               o_valid,
    output logic [width_p-1:0] o_data,
    input  logic               i_ready
);

    logic [width_p-1:0] r_mem [2];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_count;
    logic [1:0]         w_count_next;
    logic               r_ready;
    logic               w_push;
    logic               w_pop;

    assign w_push  = i_valid & r_ready;
    assign o_valid = (r_count != 2'd0);
    assign w_pop   = o_valid & i_ready;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_ready = r_ready;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    // Ready looks at the post-update occupancy, so a push is always room-safe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_next;
            r_ready <= i_enable & (w_count_next != 2'd2);
        end
    end

endmodule
`default_nettype wire

// File: rtl/hub75_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : hub75_stream_loader
//  Description : Frames a valid/ready pixel stream into linear framebuffer
//                writes, with SOF/EOL checking and error resynchronisation.
//  Revision    : 1.0 - initial release
// ============================================================================
module hub75_stream_loader
    import hub75_pkg::*;
#(
    parameter int hpixel_p = 64,
    parameter int vpixel_p = 64,
    parameter int bpp_p    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_enable,
    hub75_stream_loader_if.master  bus,
    output logic                   o_frame_done,
    output logic                   o_sync_err,
    output logic [ERR_CNT_W-1:0]   o_err_count
);

    localparam int frame_size_p = hpixel_p * vpixel_p;
    localparam int addr_width_p = clog2_min1(frame_size_p);
    localparam int c_col_w      = clog2_min1(hpixel_p);
    localparam int c_row_w      = clog2_min1(vpixel_p);
    localparam int c_data_w     = 3 * bpp_p;
    localparam int c_aw1        = addr_width_p + 1;
    localparam int c_word_w     = addr_width_p + c_data_w;
    localparam logic [c_col_w-1:0] c_last_col = c_col_w'(hpixel_p - 1);
    localparam logic [c_row_w-1:0] c_last_row = c_row_w'(vpixel_p - 1);

    loader_state_t         r_state;
    loader_state_t         w_state_next;
    logic [c_row_w-1:0]    r_row;
    logic [c_row_w-1:0]    w_row_next;
    logic [c_row_w-1:0]    w_eff_row;
    logic [c_col_w-1:0]    r_col;
    logic [c_col_w-1:0]    w_col_next;
    logic [c_col_w-1:0]    w_eff_col;
    logic [ERR_CNT_W-1:0]  r_err_count;
    logic [addr_width_p:0] w_addr_full;
    logic                  w_s_ready;
    logic                  w_beat;
    logic                  w_bad_eol;
    logic                  w_push;
    logic                  w_err;
    logic                  w_frame_done;
    logic                  w_wr_valid;
    logic [c_word_w-1:0]   w_wr_word;

    assign w_beat = bus.i_s_valid & w_s_ready;

    // A SOF beat is pixel (0,0) regardless of where the counters stand
    assign w_eff_row   = bus.i_s_sof ? '0 : r_row;
    assign w_eff_col   = bus.i_s_sof ? '0 : r_col;
    assign w_bad_eol   = bus.i_s_eol ^ (w_eff_col == c_last_col);
    assign w_addr_full = c_aw1'(w_eff_row) * c_aw1'(hpixel_p) + c_aw1'(w_eff_col);

    always_comb begin
        w_state_next = r_state;
        w_row_next   = r_row;
        w_col_next   = r_col;
        w_push       = 1'b0;
        w_err        = 1'b0;
        w_frame_done = 1'b0;
        if (!i_enable) begin
            w_state_next = IDLE;
            w_row_next   = '0;
            w_col_next   = '0;
        end else if (w_beat && (r_state == LOAD || bus.i_s_sof)) begin
            // SOF inside a frame and a bad EOL on the same beat is one error
            w_err = w_bad_eol | ((r_state == LOAD) & bus.i_s_sof);
            if (w_bad_eol) begin
                w_state_next = IDLE;
                w_row_next   = '0;
                w_col_next   = '0;
            end else if (!w_addr_full[addr_width_p]) begin
                w_push = 1'b1;
                if (bus.i_s_eol && (w_eff_row == c_last_row)) begin
                    w_frame_done = 1'b1;
                    w_state_next = IDLE;
                    w_row_next   = '0;
                    w_col_next   = '0;
                end else if (bus.i_s_eol) begin
                    w_state_next = LOAD;
                    w_row_next   = w_eff_row + c_row_w'(1);
                    w_col_next   = '0;
                end else begin
                    w_state_next = LOAD;
                    w_row_next   = w_eff_row;
                    w_col_next   = w_eff_col + c_col_w'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_err_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_row   <= w_row_next;
            r_col   <= w_col_next;
            if (w_err && (r_err_count != {ERR_CNT_W{1'b1}})) begin
                r_err_count <= r_err_count + ERR_CNT_W'(1);
            end
        end
    end

    hub75_skid_buf #(
        .width_p (c_word_w)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .i_enable (i_enable),
        .i_valid  (w_push),
        .i_data   ({w_addr_full[addr_width_p-1:0], bus.i_s_data}),
        .o_ready  (w_s_ready),
        .o_valid  (w_wr_valid),
        .o_data   (w_wr_word),
        .i_ready  (bus.i_framebuf_wr_ready)
    );

    assign bus.o_s_ready          = w_s_ready;
    assign bus.o_framebuf_wr_en   = w_wr_valid;
    assign bus.o_framebuf_wr_addr = w_wr_word[c_word_w-1:c_data_w];
    assign bus.o_framebuf_wr_data = w_wr_word[c_data_w-1:0];
    assign o_frame_done           = w_frame_done;
    assign o_sync_err             = w_err;
    assign o_err_count            = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_hub75_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hub75_stream_loader
//  Description : Randomized self-checking bench with a pixel-index frame model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hub75_stream_loader;
    import hub75_pkg::*;

    localparam int H   = 4;
    localparam int V   = 2;
    localparam int BPP = 8;
    localparam int N   = H * V;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_enable = 1'b1;
    logic       o_frame_done;
    logic       o_sync_err;
    logic [7:0] o_err_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: expected writes pending at the port, framing position
    bit          m_in_frame = 1'b0;
    int          m_next = 0;
    int          m_errs = 0;
    int          q_addr[$];
    logic [23:0] q_data[$];

    bit          exp_ready = 1'b0;
    bit          prev_stall = 1'b0;
    logic [2:0]  prev_addr = '0;
    logic [23:0] prev_data = '0;
    int          rdy_mode = 0;
    int          gap_max = 0;
    int          beats_sent = 0;
    int          n_writes = 0;
    int          n_fd = 0;

    hub75_stream_loader_if #(.hpixel_p(H), .vpixel_p(V), .bpp_p(BPP)) bus ();

    hub75_stream_loader #(.hpixel_p(H), .vpixel_p(V), .bpp_p(BPP)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_enable     (i_enable),
        .bus          (bus),
        .o_frame_done (o_frame_done),
        .o_sync_err   (o_sync_err),
        .o_err_count  (o_err_count)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_beat(input bit sof, input bit eol, input logic [23:0] d,
                              output bit fd, output bit se);
        int idx;
        bit bad;
        fd = 1'b0;
        se = 1'b0;
        if (!m_in_frame && !sof) return;
        idx = sof ? 0 : m_next;
        bad = (eol != ((idx % H) == H - 1));
        se  = (m_in_frame && sof) || bad;
        if (se && m_errs < 255) m_errs++;
        if (bad) begin
            m_in_frame = 1'b0;
            return;
        end
        q_addr.push_back(idx);
        q_data.push_back(d);
        if (idx == N - 1) begin
            fd = 1'b1;
            m_in_frame = 1'b0;
        end else begin
            m_in_frame = 1'b1;
            m_next = idx + 1;
        end
    endtask

    always @(negedge clk) begin : monitor
        bit exp_fd;
        bit exp_se;
        int a;
        logic [23:0] d;
        if (rst) begin
            exp_ready  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check_value("err_count", o_err_count, m_errs);
            check_value("s_ready", bus.o_s_ready, exp_ready);
            if (prev_stall) begin
                check_value("stall_wr_en", bus.o_framebuf_wr_en, 1);
                check_value("stall_addr", bus.o_framebuf_wr_addr, prev_addr);
                check_value("stall_data", bus.o_framebuf_wr_data, prev_data);
            end
            exp_fd = 1'b0;
            exp_se = 1'b0;
            if (bus.i_s_valid && bus.o_s_ready)
                model_beat(bus.i_s_sof, bus.i_s_eol, bus.i_s_data, exp_fd, exp_se);
            check_value("frame_done", o_frame_done, exp_fd);
            check_value("sync_err", o_sync_err, exp_se);
            if (o_frame_done) n_fd++;
            if (bus.o_framebuf_wr_en && bus.i_framebuf_wr_ready) begin
                n_writes++;
                check_value("wr_expected", (q_addr.size() != 0), 1);
                if (q_addr.size() != 0) begin
                    a = q_addr.pop_front();
                    d = q_data.pop_front();
                    check_value("wr_addr", bus.o_framebuf_wr_addr, a);
                    check_value("wr_data", bus.o_framebuf_wr_data, d);
                end
            end
            prev_stall = bus.o_framebuf_wr_en && !bus.i_framebuf_wr_ready;
            prev_addr  = bus.o_framebuf_wr_addr;
            prev_data  = bus.o_framebuf_wr_data;
            exp_ready  = i_enable && (q_addr.size() < 2);
        end
    end

    initial begin : wr_ready_drv
        bus.i_framebuf_wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.i_framebuf_wr_ready = 1'b1;
                1:       bus.i_framebuf_wr_ready = ~bus.i_framebuf_wr_ready;
                2:       bus.i_framebuf_wr_ready = 1'($urandom_range(0, 1));
                default: bus.i_framebuf_wr_ready = 1'b0;
            endcase
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Entered and left at posedge+1
    task automatic send_beat(input bit sof, input bit eol, input logic [23:0] d);
        int waited;
        bit done;
        waited = 0;
        done = 1'b0;
        if (gap_max > 0) idle($urandom_range(0, gap_max));
        bus.i_s_valid = 1'b1;
        bus.i_s_sof   = sof;
        bus.i_s_eol   = eol;
        bus.i_s_data  = d;
        while (!done) begin
            @(negedge clk);
            if (bus.o_s_ready) done = 1'b1;
            @(posedge clk);
            #1;
            waited++;
            if (!done && waited > 200) begin
                check_value("beat_accept", done, 1);
                done = 1'b1;
            end
        end
        bus.i_s_valid = 1'b0;
        bus.i_s_sof   = 1'b0;
        bus.i_s_eol   = 1'b0;
        beats_sent++;
    endtask

    task automatic send_frame(input bit seq_data);
        pixel_t px;
        for (int i = 0; i < N; i++) begin
            px = seq_data ? pixel_t'(i + 1) : pixel_t'($urandom);
            send_beat(i == 0, (i % H) == H - 1, px);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q_addr.size() != 0 || bus.o_framebuf_wr_en) && t < 300) begin
            idle(1);
            t++;
        end
        idle(1);
        check_value("drain_left", q_addr.size(), 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int w0;
        int f0;
        pixel_t px;
        bus.i_s_valid = 1'b0;
        bus.i_s_sof   = 1'b0;
        bus.i_s_eol   = 1'b0;
        bus.i_s_data  = '0;
        #2;
        check_value("rst_ready", bus.o_s_ready, 0);
        check_value("rst_wr_en", bus.o_framebuf_wr_en, 0);
        check_value("rst_addr", bus.o_framebuf_wr_addr, 0);
        check_value("rst_data", bus.o_framebuf_wr_data, 0);
        check_value("rst_err_cnt", o_err_count, 0);
        check_value("rst_sync_err", o_sync_err, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // 1: clean frame
        w0 = n_writes; f0 = n_fd;
        send_frame(1'b1);
        drain();
        check_value("t1_writes", n_writes - w0, 8);
        check_value("t1_frames", n_fd - f0, 1);
        check_value("t1_err_cnt", o_err_count, 0);

        // 2: backpressure
        w0 = n_writes; f0 = n_fd; beats_sent = 0;
        fork
            send_frame(1'b0);
            begin
                while (beats_sent < 2) idle(1);
                rdy_mode = 3;
                idle(3);
                rdy_mode = 1;
            end
        join
        drain();
        rdy_mode = 0;
        check_value("t2_writes", n_writes - w0, 8);
        check_value("t2_frames", n_fd - f0, 1);

        // 3: early EOL then orphan beats then a clean frame
        w0 = n_writes;
        send_beat(1'b1, 1'b0, 24'h0000A0);
        send_beat(1'b0, 1'b0, 24'h0000A1);
        send_beat(1'b0, 1'b1, 24'h0000A2);
        for (int i = 0; i < 3; i++) send_beat(1'b0, 1'($urandom_range(0, 1)), 24'($urandom));
        drain();
        check_value("t3_writes", n_writes - w0, 2);
        check_value("t3_err_cnt", o_err_count, 1);
        w0 = n_writes;
        send_frame(1'b0);
        drain();
        check_value("t3_refill", n_writes - w0, 8);

        // 4: SOF on beat 5 restarts the frame
        w0 = n_writes; f0 = n_fd;
        for (int i = 0; i < 5; i++) send_beat(i == 0, i == 3, 24'($urandom));
        send_beat(1'b1, 1'b0, 24'h55AA55);
        for (int i = 1; i < N; i++) send_beat(1'b0, (i % H) == H - 1, 24'($urandom));
        drain();
        check_value("t4_writes", n_writes - w0, 13);
        check_value("t4_frames", n_fd - f0, 1);
        check_value("t4_err_cnt", o_err_count, 2);

        // Random frames with occasional framing faults and random write stalls
        rdy_mode = 2; gap_max = 2;
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < N; i++) begin
                px = pixel_t'($urandom);
                send_beat((i == 0) ^ ($urandom_range(0, 15) == 0),
                          ((i % H) == H - 1) ^ ($urandom_range(0, 15) == 0), px);
            end
        end
        drain();
        rdy_mode = 0; gap_max = 0;

        // 5: saturation, then enable drop mid-frame
        for (int i = 0; i < 300; i++) send_beat(1'b1, 1'b1, 24'($urandom));
        idle(2);
        check_value("t5_saturated", o_err_count, 255);
        rdy_mode = 3;
        w0 = n_writes;
        send_beat(1'b1, 1'b0, 24'h111111);
        send_beat(1'b0, 1'b0, 24'h222222);
        i_enable = 1'b0;
        m_in_frame = 1'b0;
        idle(2);
        check_value("t5_ready_off", bus.o_s_ready, 0);
        rdy_mode = 0;
        drain();
        check_value("t5_drained", n_writes - w0, 2);
        i_enable = 1'b1;
        idle(2);
        w0 = n_writes;
        send_beat(1'b0, 1'b0, 24'h333333);
        drain();
        check_value("t5_idle_drop", n_writes - w0, 0);

        // 6: reset mid-frame
        rdy_mode = 2;
        for (int i = 0; i < 4; i++) send_beat(i == 0, i == 3, 24'($urandom));
        bus.i_s_valid = 1'b1;
        bus.i_s_data  = 24'h444444;
        #2;
        rst = 1'b1;
        q_addr.delete();
        q_data.delete();
        m_in_frame = 1'b0;
        m_errs = 0;
        #1;
        check_value("t6_wr_en", bus.o_framebuf_wr_en, 0);
        check_value("t6_ready", bus.o_s_ready, 0);
        check_value("t6_addr", bus.o_framebuf_wr_addr, 0);
        check_value("t6_data", bus.o_framebuf_wr_data, 0);
        check_value("t6_err_cnt", o_err_count, 0);
        check_value("t6_frame_done", o_frame_done, 0);
        bus.i_s_valid = 1'b0;
        rdy_mode = 0;
        idle(2);
        rst = 1'b0;
        idle(1);
        w0 = n_writes; f0 = n_fd;
        send_frame(1'b1);
        drain();
        check_value("t6_writes", n_writes - w0, 8);
        check_value("t6_frames", n_fd - f0, 1);
        check_value("t6_err_final", o_err_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
